// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC generation, single in-flight imem read, fetch queue, redirect and halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024,
    parameter int          FQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_instr,
    output logic [31:0] fq_pc,
    output logic        halted,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int          PTR_W   = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int          CNT_W   = PTR_W + 1;
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALTED} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [31:0]        inflight_pc_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               halted_q;
    logic [31:0]        instr_mem [FQ_DEPTH];
    logic [31:0]        pc_mem    [FQ_DEPTH];

    logic in_bounds, credit_ok, issue, resp_live, push, stop_seen, pop, not_empty;

    always_comb begin
        not_empty = (count_q != '0);
        in_bounds = (fetch_pc_q <= LAST_PC);
        // Credits use registered occupancy only, so a same-cycle pop never frees a slot.
        credit_ok = ((count_q + CNT_W'(inflight_q)) < CNT_W'(FQ_DEPTH));
        issue     = (state_q == S_FETCH) && !redirect_valid && credit_ok && in_bounds;
        resp_live = inflight_q && (state_q == S_FETCH) && !redirect_valid;
        push      = resp_live && !imem_stop;
        stop_seen = resp_live && imem_stop;
        pop       = not_empty && fq_ready && !redirect_valid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect wins from any state
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (stop_seen || !in_bounds) state_d = S_DRAIN;
                S_DRAIN:  if (!not_empty && !push)     state_d = S_HALTED;
                S_HALTED: state_d = S_HALTED;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Output logic
    always_comb begin
        imem_pc  = fetch_pc_q;
        fq_valid = not_empty;
        fq_instr = not_empty ? instr_mem[rd_ptr_q] : 32'h0;
        fq_pc    = not_empty ? pc_mem[rd_ptr_q]    : 32'h0;
        halted   = halted_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halted_q   <= (state_d == S_HALTED);
        end
    end

    // Queue storage and in-flight PC are data only; no reset needed
    always_ff @(posedge clk) begin
        if (issue) inflight_pc_q <= fetch_pc_q;
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_instr;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic        stall_credit;

    assign stall_credit = (state_q == S_FETCH) && !redirect_valid && in_bounds && !credit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (push)         perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall_credit) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_controller;

    localparam int DEPTH = 4;
    localparam int BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        imem_stop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fq_valid;
    logic        fq_ready;
    logic [31:0] fq_instr;
    logic [31:0] fq_pc;
    logic        halted;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int errs = 0;
    int chks = 0;
    bit chk_en = 1'b0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    fetch_controller #(
        .RESET_PC  (32'h0),
        .IMEM_BYTES(BYTES),
        .FQ_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .imem_stop     (imem_stop),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fq_valid      (fq_valid),
        .fq_ready      (fq_ready),
        .fq_instr      (fq_instr),
        .fq_pc         (fq_pc),
        .halted        (halted),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a < BYTES) return mem[a[9:2]];
        return 32'h0;
    endfunction

    // instructionMemory: 1-cycle synchronous read, stop on all-zero word
    always @(posedge clk) begin
        imem_instr <= memword(imem_pc);
        imem_stop  <= (memword(imem_pc) == 32'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
    localparam int RUN = 0, DRAINING = 1, STOPPED = 2;

    entry_t      m_q[$];
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_halted;
    logic [31:0] m_nfetch, m_nstall;
    bit          t_fits, t_inmem, t_go, t_push, t_stop;
    int          t_size;
    logic [31:0] t_word;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_mode = RUN; m_pc = 32'h0; m_pend = 1'b0; m_halted = 1'b0;
            m_nfetch = 0; m_nstall = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc = {redirect_pc[31:2], 2'b00};
            m_mode = RUN; m_halted = 1'b0;
        end else begin
            t_size  = m_q.size();
            t_fits  = (t_size + int'(m_pend)) < DEPTH;
            t_inmem = (m_pc <= BYTES - 4);
            t_word  = memword(m_pend_pc);
            t_push  = m_pend && (m_mode == RUN) && (t_word != 0);
            t_stop  = m_pend && (m_mode == RUN) && (t_word == 0);
            t_go    = (m_mode == RUN) && t_fits && t_inmem;
            if ((m_mode == RUN) && t_inmem && !t_fits) m_nstall++;
            if (t_push) m_nfetch++;
            if ((m_mode == RUN) && (t_stop || !t_inmem)) m_mode = DRAINING;
            else if ((m_mode == DRAINING) && (t_size == 0)) m_mode = STOPPED;
            if ((t_size > 0) && fq_ready) void'(m_q.pop_front());
            if (t_push) m_q.push_back('{pc: m_pend_pc, instr: t_word});
            m_pend = t_go;
            if (t_go) begin m_pend_pc = m_pc; m_pc = m_pc + 4; end
            m_halted = (m_mode == STOPPED);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_fq_valid", fq_valid, (m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("model_fq_pc", fq_pc, m_q[0].pc);
                check("model_fq_instr", fq_instr, m_q[0].instr);
            end else begin
                check("model_fq_pc", fq_pc, 32'h0);
                check("model_fq_instr", fq_instr, 32'h0);
            end
            check("model_halted", halted, m_halted);
            check("model_imem_pc", imem_pc, m_pc);
`ifdef FETCH_PERF_CNT_EN
            check("model_perf_fetch", perf_fetch_cnt, m_nfetch);
            check("model_perf_stall", perf_stall_cnt, m_nstall);
`else
            check("model_perf_fetch", perf_fetch_cnt, 32'h0);
            check("model_perf_stall", perf_stall_cnt, 32'h0);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic v, input logic [31:0] pc);
        @(negedge clk);
        check({name, "_valid"}, fq_valid, v);
        check({name, "_pc"}, fq_pc, pc);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; fq_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h13 + (i << 12);
        mem[0] = 32'h13; mem[1] = 32'h13; mem[2] = 32'h13;
        mem[3] = 32'h0;  mem[11] = 32'h0;
        tick(); chk_en = 1'b1;
        tick(); rst = 1'b0;

        // Stop word at 0xC
        @(negedge clk);
        check("rst_fq_valid", fq_valid, 1'b0);
        check("rst_fq_instr", fq_instr, 32'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_imem_pc", imem_pc, 32'h0);
        tick(); tick(); lit("t1_c2", 1'b1, 32'h0);
        check("t1_c2_instr", fq_instr, 32'h13);
        tick(); lit("t1_c3", 1'b1, 32'h4);
        tick(); lit("t1_c4", 1'b1, 32'h8);
        tick(); lit("t1_c5", 1'b0, 32'h0);
        check("t1_c5_halted", halted, 1'b0);
        tick(); @(negedge clk);
        check("t1_c6_halted", halted, 1'b1);
        check("t1_c6_imem_pc", imem_pc, 32'h14);
        repeat (4) tick();
        lit("t1_idle", 1'b0, 32'h0);

        // Redirect out of halt to 0x20; stop word at 0x2C halts again
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_halted_clr", halted, 1'b0);
        check("t4_imem_pc", imem_pc, 32'h20);
        tick(); tick(); lit("t4_r3", 1'b1, 32'h20);
        repeat (6) tick();
        @(negedge clk); check("t4_rehalt", halted, 1'b1);

        // Redirect to the last word; 0x400 never issued
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h3FC;
        tick(); redirect_valid = 1'b0;
        @(negedge clk); check("t5_r1_imem_pc", imem_pc, 32'h3FC);
        tick(); lit("t5_r2", 1'b0, 32'h0);
        tick(); lit("t5_r3", 1'b1, 32'h3FC);
        check("t5_r3_instr", fq_instr, 32'h13 + (32'd255 << 12));
        tick(); @(negedge clk); check("t5_r4_halted", halted, 1'b0);
        tick(); @(negedge clk);
        check("t5_r5_halted", halted, 1'b1);
        check("t5_r5_imem_pc", imem_pc, 32'h400);

        // Backpressure: 4 entries held, imem_pc frozen, then gapless release
        rst = 1'b1; fq_ready = 1'b0;
        mem[3] = 32'h13 + (32'd3 << 12); mem[11] = 32'h13 + (32'd11 << 12);
        tick(); rst = 1'b0;
        repeat (9) tick();
        lit("t2_c9", 1'b1, 32'h0);
        check("t2_c9_imem_pc", imem_pc, 32'h10);
        tick(); fq_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lit("t2_drain", 1'b1, 32'(k * 4));
            tick();
        end

        // Redirect with credits exhausted and a read in flight
        rst = 1'b1; fq_ready = 1'b0;
        tick(); rst = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        tick(); redirect_valid = 1'b0;
        lit("t3_r1", 1'b0, 32'h0);
        check("t3_r1_imem_pc", imem_pc, 32'h40);
        tick(); lit("t3_r2", 1'b0, 32'h0);
        tick(); lit("t3_r3", 1'b1, 32'h40);

        // Reset mid-stream with 3 entries queued
        tick(); tick(); rst = 1'b1;
        lit("t6_pre", 1'b1, 32'h40);
        tick(); rst = 1'b0; fq_ready = 1'b1;
        lit("t6_r1", 1'b0, 32'h0);
        check("t6_r1_imem_pc", imem_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("t6_perf_fetch", perf_fetch_cnt, 32'h0);
        check("t6_perf_stall", perf_stall_cnt, 32'h0);
`endif
        tick(); lit("t6_c1", 1'b0, 32'h0);
        tick(); lit("t6_c2", 1'b1, 32'h0);
        repeat (5) tick();

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Fetch-stage sequencer for the instructionMemory block: 1024-byte, byte-addressed, little-endian array with 1-cycle synchronous read, outputs instr/stop.
- Generates the PC stream and tracks the single in-flight read.
- Buffers returned instructions with their PCs in a small fetch queue with valid/ready to decode/rename.
- Handles branch/exception redirects and halts on the all-zero stop instruction or on running off the end of memory.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- IMEM_BYTES, 1024, instruction memory size in bytes
- FQ_DEPTH, 4, fetch queue entries; power of two, >=2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_pc  out  32  PC presented to instructionMemory; equals internal fetch_pc register
- imem_instr  in  32  instructionMemory instr, valid one cycle after issue
- imem_stop  in  1  instructionMemory stop, same timing as imem_instr
- redirect_valid  in  1  one-cycle redirect pulse from branch resolution/commit
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- fq_valid  out  1  fetch queue head valid
- fq_ready  in  1  downstream accepts head; pop when fq_valid & fq_ready
- fq_instr  out  32  head instruction; 0 when empty
- fq_pc  out  32  head PC; 0 when empty
- halted  out  1  stop reached and queue drained
- perf_fetch_cnt  out  32  instructions pushed (optional feature)
- perf_stall_cnt  out  32  cycles with issue blocked by credits (optional feature)

Behaviour:
- Clock and reset: one clock clk; synchronous active-high reset rst.
- Reset values:
  - fetch_pc = RESET_PC, state = FETCH, inflight = 0, queue count = 0.
  - fq_valid = 0, fq_instr = 0, fq_pc = 0, halted = 0, perf counters = 0.
  - Reset mid-operation discards queue contents and any in-flight response.
- States:
  - FETCH: issue permitted.
  - DRAIN: stop seen; no issue; queue still drains.
  - HALTED: queue empty after stop; halted = 1.
- Issue rule, cycle t:
  - Issue when state == FETCH, !redirect_valid, count + inflight < FQ_DEPTH (registered values; a same-cycle pop is not credited), and fetch_pc <= IMEM_BYTES-4.
  - On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - Otherwise inflight <= 0 and fetch_pc holds.
- Response, cycle t+1, when inflight:
  - Discard if state != FETCH or redirect_valid is high.
  - If imem_stop = 1: discard and go to DRAIN.
  - Else: push {imem_instr, inflight_pc}.
- Latency and throughput:
  - Pushed entry is visible at fq_valid in cycle t+2.
  - First reset fetch reaches fq_valid 2 cycles after rst deasserts.
  - Sustained 1 instr/cycle when fq_ready is held high.
- Bounds: in FETCH with fetch_pc > IMEM_BYTES-4, no issue; go to DRAIN.
- DRAIN -> HALTED when count == 0 and no push. The halted register asserts the following cycle.
- Redirect has highest priority, in any state:
  - Queue flushed (count <= 0, pop ignored).
  - In-flight response of the next cycle discarded; no issue this cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; state <= FETCH; halted <= 0.
  - Target issues at r+1; fq_valid with target PC at r+3.
- Queue:
  - Circular buffer; pointers wrap modulo FQ_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Credit rule makes push-when-full impossible; asserting on it is allowed.
  - Pop when empty is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments per push.
  - perf_stall_cnt increments per cycle in FETCH where issue is blocked only by the credit check.
  - Both wrap at 2^32; cleared by rst.
  - Redirect does not clear them.
- Undefined: both ports tied to 0; no counter registers.

Test Plan:
- Memory words 0x00000013 at 0x0, 0x4, 0x8, zero at 0xC; fq_ready = 1 -> fq_pc 0x0/0x4/0x8 on cycles 2/3/4; the 0x10 fetch is discarded; halted = 1 by cycle 6; no further pushes.
- Continuous nonzero code, fq_ready = 0 for 10 cycles -> exactly 4 entries held (PCs 0x0–0xC), imem_pc frozen at 0x10; release -> 0x0, 0x4, … with no gap or duplicate.
- Queue full with an in-flight read, redirect_valid pulse at r with redirect_pc = 0x43 -> fq_valid = 0 at r+1, r+2; fq_pc = 0x40 at r+3.
- While halted, redirect to 0x20 -> halted = 0 next cycle, fetching resumes, fq_pc = 0x20 delivered.
- Redirect to 0x3FC with a nonzero word there -> 0x3FC delivered; 0x400 never issued; halted = 1.
- rst asserted for 1 cycle mid-stream with 3 entries queued -> fq_valid = 0 and imem_pc = RESET_PC next cycle; restart delivers PC 0x0 two cycles after release; with FETCH_PERF_CNT_EN, counters read 0 after reset.
